sprite_motion_ctrl: RTL

Per-frame position controller for one 32x32 sprite renderer. Detects the falling edge of vsync, steps the sprite position by a signed velocity every FRAME_DIV frames, and bounces off the screen edges. Commits sprite_x/sprite_y atomically for the renderer. A valid/ready load port lets game logic place the sprite and set its velocity.

---
 rtl/sprite_motion_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/sprite_motion_ctrl.sv
// Per-frame position controller for a single sprite: vsync-fall detection, divided stepping,
// edge bounce and atomic position commit. Define SPRITE_MOTION_WRAP_EN to wrap at the edges instead.
module sprite_motion_ctrl #(
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int SPRITE_W  = 32,
    parameter int SPRITE_H  = 32,
    parameter int FRAME_DIV = 1,
    parameter int INIT_X    = 304,
    parameter int INIT_Y    = 224
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       enable,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [9:0] load_x,
    input  logic [9:0] load_y,
    input  logic [3:0] load_dx,
    input  logic [3:0] load_dy,
    output logic [9:0] sprite_x,
    output logic [9:0] sprite_y,
    output logic       frame_tick,
    output logic       bounce_x,
    output logic       bounce_y
);

    localparam int          XMAX   = SCREEN_W - SPRITE_W;
    localparam int          YMAX   = SCREEN_H - SPRITE_H;
    localparam logic [10:0] XMAX_W = 11'(XMAX);
    localparam logic [10:0] YMAX_W = 11'(YMAX);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STEP_X = 2'd1,
        ST_STEP_Y = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    function automatic logic [9:0] clamp_pos(input logic [9:0] pos, input logic [10:0] lim);
        return ({1'b0, pos} > lim) ? lim[9:0] : pos;
    endfunction

    // -8 has no positive mirror in 4 bits, so it is pulled in to -7.
    function automatic logic [3:0] sat_vel(input logic [3:0] vel);
        return (vel == 4'b1000) ? 4'b1001 : vel;
    endfunction

    // Returns {edge_hit, next_velocity, next_position} for one axis.
    function automatic logic [14:0] step_axis(input logic [9:0] pos, input logic [3:0] vel,
                                              input logic [10:0] lim);
        logic [10:0] nx;
        logic [9:0]  np;
        logic [3:0]  nv;
        logic        hit;
        nx  = {1'b0, pos} + {{7{vel[3]}}, vel};
        np  = nx[9:0];
        nv  = vel;
        hit = 1'b0;
        if (nx[10]) begin
`ifdef SPRITE_MOTION_WRAP_EN
            np = 10'(nx + lim + 11'd1);
`else
            np = 10'd0;
            nv = 4'd0 - vel;
`endif
            hit = 1'b1;
        end else if (nx > lim) begin
`ifdef SPRITE_MOTION_WRAP_EN
            np = 10'(nx - lim - 11'd1);
`else
            np = lim[9:0];
            nv = 4'd0 - vel;
`endif
            hit = 1'b1;
        end else begin
            np = nx[9:0];
        end
        return {hit, nv, np};
    endfunction

    logic        sync1_r, sync2_r, prev_r, frame_tick_r;
    logic [7:0]  frame_cnt_r;
    state_t      state_r, state_nxt_s;
    logic [9:0]  sprite_x_r, sprite_y_r, shadow_x_r;
    logic [3:0]  dx_r, dy_r;
    logic        bx_flag_r, bounce_x_r, bounce_y_r, load_ready_r;
    logic        load_hs_s, cnt_wrap_s, step_due_s;
    logic [14:0] step_x_s, step_y_s;

    assign load_hs_s  = load_valid && load_ready_r;
    assign cnt_wrap_s = (frame_cnt_r == 8'(FRAME_DIV - 1));
    assign step_due_s = frame_tick_r && cnt_wrap_s;
    assign step_x_s   = step_axis(sprite_x_r, dx_r, XMAX_W);
    assign step_y_s   = step_axis(sprite_y_r, dy_r, YMAX_W);

    // vsync synchronizer, edge flop and registered falling-edge pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r      <= 1'b1;
            sync2_r      <= 1'b1;
            prev_r       <= 1'b1;
            frame_tick_r <= 1'b0;
        end else begin
            sync1_r      <= vsync;
            sync2_r      <= sync1_r;
            prev_r       <= sync2_r;
            frame_tick_r <= prev_r & ~sync2_r;
        end
    end

    // Frame divider; keeps counting regardless of enable, loads or FSM state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_r <= 8'd0;
        end else if (frame_tick_r) begin
            frame_cnt_r <= cnt_wrap_s ? 8'd0 : frame_cnt_r + 8'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // FSM state register plus registered load_ready
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            load_ready_r <= 1'b1;
        end else begin
            state_r      <= state_nxt_s;
            load_ready_r <= (state_nxt_s == ST_IDLE);
        end
    end

    // Next-state logic; a tick arriving outside IDLE is simply not acted on
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (step_due_s && enable && !load_hs_s) begin
                    state_nxt_s = ST_STEP_X;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_STEP_X: state_nxt_s = ST_STEP_Y;
            ST_STEP_Y: state_nxt_s = ST_COMMIT;
            ST_COMMIT: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Position/velocity datapath. x is parked in the shadow register during STEP_X and
    // written together with the freshly computed y on the edge into COMMIT, so the pair
    // (and the bounce pulses) become visible in the COMMIT cycle, 3 cycles after frame_tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sprite_x_r <= 10'(INIT_X);
            sprite_y_r <= 10'(INIT_Y);
            shadow_x_r <= 10'(INIT_X);
            dx_r       <= 4'd1;
            dy_r       <= 4'd1;
            bx_flag_r  <= 1'b0;
            bounce_x_r <= 1'b0;
            bounce_y_r <= 1'b0;
        end else begin
            bounce_x_r <= 1'b0;
            bounce_y_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (load_hs_s) begin
                        sprite_x_r <= clamp_pos(load_x, XMAX_W);
                        sprite_y_r <= clamp_pos(load_y, YMAX_W);
                        dx_r       <= sat_vel(load_dx);
                        dy_r       <= sat_vel(load_dy);
                    end else begin
                        sprite_x_r <= sprite_x_r;
                    end
                end
                ST_STEP_X: begin
                    shadow_x_r <= step_x_s[9:0];
                    dx_r       <= step_x_s[13:10];
                    bx_flag_r  <= step_x_s[14];
                end
                ST_STEP_Y: begin
                    sprite_x_r <= shadow_x_r;
                    sprite_y_r <= step_y_s[9:0];
                    dy_r       <= step_y_s[13:10];
                    bounce_x_r <= bx_flag_r;
                    bounce_y_r <= step_y_s[14];
                end
                ST_COMMIT: begin
                    bx_flag_r <= 1'b0;
                end
                default: begin
                    bx_flag_r <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready = load_ready_r;
    assign sprite_x   = sprite_x_r;
    assign sprite_y   = sprite_y_r;
    assign frame_tick = frame_tick_r;
    assign bounce_x   = bounce_x_r;
    assign bounce_y   = bounce_y_r;

endmodule
